// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter: wrap/saturate at a programmable limit, with load, compare-match and sticky overflow.
// A step updates count/tc/ovf on the same edge; match is combinational from count. No backpressure: inputs are sampled every cycle.
module prescaled_updown_counter #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic [PS_W-1:0]  prescale,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]  pc_q, pc_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             boundary;

    // '>=' lets a runtime decrease of prescale fire on the next enabled cycle.
    assign step     = en && (pc_q >= prescale);
    assign boundary = dir ? (count_q >= limit) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        pc_d    = pc_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
            pc_d    = '0;
        end else if (en) begin
            if (step) begin
                pc_d = '0;
                if (boundary) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    if (dir) count_d = sat ? limit : '0;
                    else     count_d = sat ? '0 : limit;
                end else if (dir) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            pc_q    <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign match = (count_q == cmp_val);

endmodule
